mic_peak_tracker: RTL and testbench
===================================

// Module: mic_peak_tracker
// PURPOSE
//   Upstream of the audio level display stage. Takes the 12-bit microphone ADC sample stream
//   (one mic_valid strobe per conversion) and produces two registered 12-bit levels:
//   - peak_output: maximum over a fixed window of samples.
//   - sample_output: decimated instantaneous snapshot.
//   Both are floored at 2048 (mid-scale, silence), so the display always receives a value in 2048..4095.
// PARAMETERS
//   WINDOW    4000  mic_valid samples per peak window (>=2); 4000 = 200 ms at 20 kHz
//   SNAP_DIV  1000  mic_valid samples between sample_output updates (>=1)
//   FLOOR     2048  clamp floor applied to every sample before use
// PORTS
//   clock          in   1   system clock; all logic on posedge
//   reset_n        in   1   synchronous active-low reset
//   enable         in   1   1 = track; 0 = idle, outputs frozen
//   mic_valid      in   1   1-cycle strobe: mic_in holds a new sample this cycle
//   mic_in         in   12  raw ADC sample, unsigned
//   peak_output    out  12  peak of last completed window, floored
//   sample_output  out  12  last snapshot sample, floored
//   peak_valid     out  1   1-cycle pulse when peak_output updates
//   sample_valid   out  1   1-cycle pulse when sample_output updates
// BEHAVIOUR
//   Reset (reset_n=0 at posedge):
//   - state=IDLE, win_cnt=0, snap_cnt=0, run_max=FLOOR.
//   - peak_output=FLOOR, sample_output=FLOOR, peak_valid=0, sample_valid=0.
//   - Reset overrides all other inputs in that cycle.
//   Clamp: s = (mic_in < FLOOR) ? FLOOR : mic_in. All compares are unsigned 12-bit; no overflow is possible.
//   States:
//   - IDLE: enable=1 -> ACCUM; load win_cnt=0, snap_cnt=0, run_max=FLOOR.
//     A mic_valid in the IDLE->ACCUM transition cycle is ignored.
//   - ACCUM: enable=0 -> IDLE. The partial window is discarded (counters cleared, run_max=FLOOR);
//     peak_output and sample_output hold their values.
//   ACCUM, mic_valid=1:
//   - win_cnt < WINDOW-1: run_max <= max(run_max, s); win_cnt++.
//   - win_cnt == WINDOW-1: peak_output <= max(run_max, s); peak_valid=1 next cycle;
//     run_max <= FLOOR; win_cnt <= 0. The closing sample belongs to the closing window.
//   - snap_cnt == SNAP_DIV-1: sample_output <= s; sample_valid=1 next cycle; snap_cnt <= 0.
//     Otherwise snap_cnt++. The snapshot path is independent of the window path.
//     Both paths may fire on the same strobe.
//   ACCUM, mic_valid=0: no state change; peak_valid and sample_valid return to 0.
//   Latency:
//   - Outputs and their valid pulses are registered 1 clock after the qualifying mic_valid edge.
//   - Valid pulses are exactly 1 cycle, even if mic_valid is held high on consecutive cycles.
//     Each high cycle counts as one sample.
//   - enable=0 together with mic_valid=1: enable wins; the sample is dropped, no pulse.
//   Window and snapshot counters wrap to 0 only at the terminal count, never by overflow.
//   Counter width: $clog2 of the parameter.
// TESTING (WINDOW=4, SNAP_DIV=2, FLOOR=2048)
//   1. Reset: reset_n=0 for 2 clocks with mic_valid pulsing -> peak_output=sample_output=2048,
//      both valid pulses stay 0.
//   2. Window peak: enable=1, samples 2100,3900,2500,2200 -> 1 cycle after the 4th strobe,
//      peak_output=3900 and peak_valid pulses once. Next samples 2050,2060,2070,2080 -> peak_output=2080
//      (run_max was cleared; the old peak is not retained).
//   3. Floor/snapshot: samples 100,0,4095,1000 -> sample_output=2048 after the 2nd strobe and
//      2048 after the 4th; peak_output=4095.
//   4. Closing-sample edge: samples 2200,2200,2200,4000 -> peak_output=4000. The peak_valid and
//      sample_valid pulses coincide in the same cycle.
//   5. Abort: 3 samples of 3500, then enable=0, then enable=1 and samples 2300 x4 -> peak_output=2300.
//      peak_output is unchanged during the idle period.
//   6. Back-to-back: mic_valid held high 8 cycles, mic_in=3000 -> two peak_valid pulses 4 cycles apart.
//      Four sample_valid pulses; peak_output=3000.

Source files
------------

// File: rtl/mic_peak_tracker.sv
// Windowed peak detector and decimated snapshot for a 12-bit mic ADC stream.
// Every sample is clamped to FLOOR first, so both outputs stay within FLOOR..4095.
module mic_peak_tracker #(
    parameter int WINDOW   = 4000,
    parameter int SNAP_DIV = 1000,
    parameter int FLOOR    = 2048
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        mic_valid,
    input  logic [11:0] mic_in,
    output logic [11:0] peak_output,
    output logic [11:0] sample_output,
    output logic        peak_valid,
    output logic        sample_valid
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int SNAP_W = (SNAP_DIV > 1) ? $clog2(SNAP_DIV) : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [SNAP_W-1:0] SNAP_LAST = SNAP_W'(SNAP_DIV - 1);
    localparam logic [11:0]       FLOOR_V   = 12'(FLOOR);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]        state_reg,        state_next;
    logic [WIN_W-1:0]  win_cnt_reg,      win_cnt_next;
    logic [SNAP_W-1:0] snap_cnt_reg,     snap_cnt_next;
    logic [11:0]       run_max_reg,      run_max_next;
    logic [11:0]       peak_reg,         peak_next;
    logic [11:0]       sample_reg,       sample_next;
    logic              peak_valid_reg,   peak_valid_next;
    logic              sample_valid_reg, sample_valid_next;

    logic [11:0] clamped;
    logic [11:0] max_with_sample;

    assign clamped         = (mic_in < FLOOR_V) ? FLOOR_V : mic_in;
    assign max_with_sample = (clamped > run_max_reg) ? clamped : run_max_reg;

    always_comb begin
        state_next        = state_reg;
        win_cnt_next      = win_cnt_reg;
        snap_cnt_next     = snap_cnt_reg;
        run_max_next      = run_max_reg;
        peak_next         = peak_reg;
        sample_next       = sample_reg;
        peak_valid_next   = 1'b0;
        sample_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // A strobe arriving on the entry cycle is deliberately dropped.
                if (enable) begin
                    state_next    = ACCUM;
                    win_cnt_next  = '0;
                    snap_cnt_next = '0;
                    run_max_next  = FLOOR_V;
                end
            end
            default: begin
                if (!enable) begin
                    state_next    = IDLE;
                    win_cnt_next  = '0;
                    snap_cnt_next = '0;
                    run_max_next  = FLOOR_V;
                end else if (mic_valid) begin
                    // The closing sample still counts toward the window it closes.
                    if (win_cnt_reg == WIN_LAST) begin
                        peak_next       = max_with_sample;
                        peak_valid_next = 1'b1;
                        run_max_next    = FLOOR_V;
                        win_cnt_next    = '0;
                    end else begin
                        run_max_next = max_with_sample;
                        win_cnt_next = win_cnt_reg + 1'b1;
                    end

                    if (snap_cnt_reg == SNAP_LAST) begin
                        sample_next       = clamped;
                        sample_valid_next = 1'b1;
                        snap_cnt_next     = '0;
                    end else begin
                        snap_cnt_next = snap_cnt_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            win_cnt_reg      <= '0;
            snap_cnt_reg     <= '0;
            run_max_reg      <= FLOOR_V;
            peak_reg         <= FLOOR_V;
            sample_reg       <= FLOOR_V;
            peak_valid_reg   <= 1'b0;
            sample_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            win_cnt_reg      <= win_cnt_next;
            snap_cnt_reg     <= snap_cnt_next;
            run_max_reg      <= run_max_next;
            peak_reg         <= peak_next;
            sample_reg       <= sample_next;
            peak_valid_reg   <= peak_valid_next;
            sample_valid_reg <= sample_valid_next;
        end
    end

    assign peak_output   = peak_reg;
    assign sample_output = sample_reg;
    assign peak_valid    = peak_valid_reg;
    assign sample_valid  = sample_valid_reg;

endmodule

// File: tb/tb_mic_peak_tracker.sv
// Directed and randomized stimulus for mic_peak_tracker, checked every cycle
// against a queue-based model of the window/snapshot behaviour.
module tb_mic_peak_tracker;

    localparam int WINDOW   = 4;
    localparam int SNAP_DIV = 2;
    localparam int FLOOR    = 2048;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mic_valid;
    logic [11:0] mic_in;
    logic [11:0] peak_output;
    logic [11:0] sample_output;
    logic        peak_valid;
    logic        sample_valid;

    int passed = 0;
    int total  = 0;

    // reference model state
    int q[$];
    int snap_n    = 0;
    bit active    = 0;
    int exp_peak  = FLOOR;
    int exp_samp  = FLOOR;
    int exp_pv    = 0;
    int exp_sv    = 0;
    int pv_count;
    int sv_count;

    mic_peak_tracker #(
        .WINDOW  (WINDOW),
        .SNAP_DIV(SNAP_DIV),
        .FLOOR   (FLOOR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .mic_valid    (mic_valid),
        .mic_in       (mic_in),
        .peak_output  (peak_output),
        .sample_output(sample_output),
        .peak_valid   (peak_valid),
        .sample_valid (sample_valid)
    );

    always #5 clock = ~clock;

    function automatic int clampv(input int x);
        return (x < FLOOR) ? FLOOR : x;
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic model_update(input bit rst_n, input bit en, input bit v, input int d);
        int s;
        int m;
        exp_pv = 0;
        exp_sv = 0;
        if (!rst_n) begin
            active = 0; q.delete(); snap_n = 0;
            exp_peak = FLOOR; exp_samp = FLOOR;
        end else if (!active) begin
            if (en) begin
                active = 1; q.delete(); snap_n = 0;
            end
        end else if (!en) begin
            active = 0; q.delete(); snap_n = 0;
        end else if (v) begin
            s = clampv(d);
            q.push_back(s);
            if (q.size() == WINDOW) begin
                m = 0;
                foreach (q[i]) if (q[i] > m) m = q[i];
                exp_peak = m;
                exp_pv = 1;
                q.delete();
            end
            snap_n++;
            if (snap_n == SNAP_DIV) begin
                exp_samp = s;
                exp_sv = 1;
                snap_n = 0;
            end
        end
    endtask

    task automatic step(input bit rst_n, input bit en, input bit v, input int d);
        @(negedge clock);
        reset_n   = rst_n;
        enable    = en;
        mic_valid = v;
        mic_in    = 12'(d);
        @(posedge clock);
        model_update(rst_n, en, v, d);
        #1;
        check("peak_output", int'(peak_output), exp_peak);
        check("sample_output", int'(sample_output), exp_samp);
        check("peak_valid", int'(peak_valid), exp_pv);
        check("sample_valid", int'(sample_valid), exp_sv);
        pv_count += int'(peak_valid);
        sv_count += int'(sample_valid);
    endtask

    task automatic sample(input int d);
        step(1, 1, 1, d);
        step(1, 1, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mic_valid = 1'b0; mic_in = '0;
        pv_count = 0; sv_count = 0;

        // 1. reset with strobes toggling
        step(0, 1, 1, 3000);
        step(0, 1, 0, 3000);
        check("reset_peak", int'(peak_output), 2048);
        check("reset_sample", int'(sample_output), 2048);
        step(1, 0, 0, 0);

        // 2. window peak, then run_max cleared
        step(1, 1, 1, 4000);               // entry cycle: strobe ignored
        sample(2100); sample(3900); sample(2500);
        step(1, 1, 1, 2200);
        check("win1_peak", int'(peak_output), 3900);
        check("win1_pv", int'(peak_valid), 1);
        step(1, 1, 0, 0);
        sample(2050); sample(2060); sample(2070); sample(2080);
        check("win2_peak", int'(peak_output), 2080);

        // 3. floor clamp and snapshot
        sample(100);
        step(1, 1, 1, 0);
        check("snap_floor0", int'(sample_output), 2048);
        step(1, 1, 0, 0);
        sample(4095); sample(1000);
        check("snap_floor1", int'(sample_output), 2048);
        check("floor_peak", int'(peak_output), 4095);

        // 4. closing sample sets peak; both pulses coincide
        sample(2200); sample(2200); sample(2200);
        step(1, 1, 1, 4000);
        check("close_peak", int'(peak_output), 4000);
        check("coincide", int'({peak_valid, sample_valid}), 3);
        step(1, 1, 0, 0);

        // 5. abort mid-window; enable=0 beats a simultaneous strobe
        sample(3500); sample(3500); sample(3500);
        step(1, 0, 1, 3900);
        step(1, 0, 0, 0);
        check("idle_hold", int'(peak_output), 4000);
        step(1, 1, 0, 0);
        sample(2300); sample(2300); sample(2300); sample(2300);
        check("abort_peak", int'(peak_output), 2300);

        // 6. back-to-back strobes
        pv_count = 0; sv_count = 0;
        for (int i = 0; i < 8; i++) step(1, 1, 1, 3000);
        step(1, 1, 0, 0);
        check("b2b_pv_count", pv_count, 2);
        check("b2b_sv_count", sv_count, 4);
        check("b2b_peak", int'(peak_output), 3000);

        // randomized traffic with occasional resets and enable drops
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 15) != 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4095)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
